idu_hazard_ctrl: RTL and testbench

Issue controller sitting after the first decode stage (IDU0 output register). It tracks long-latency destination registers in a 32-entry scoreboard and sequences the shared non-pipelined divider. It also bounds outstanding memory ops and drives pipe_stall back into the decode flops. Single-cycle ALU/MUL results are assumed forwarded elsewhere; only DIV and LOAD results are scoreboarded.

---
 rtl/idu_hazard_ctrl_pkg.sv | 25 ++
 rtl/idu_scoreboard.sv | 48 ++++
 rtl/idu_hazard_ctrl.sv | 104 ++++++++++
 tb/tb_idu_hazard_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/idu_hazard_ctrl_pkg.sv
// rtl/idu_hazard_ctrl_pkg.sv - shared types for the decode issue/hazard controller
package idu_hazard_ctrl_pkg;

  localparam int NUM_GPR = 32;
  localparam int GPR_AW  = 5;

  typedef struct packed {
    logic              rs1;
    logic [GPR_AW-1:0] rs1_addr;
    logic              rs2;
    logic [GPR_AW-1:0] rs2_addr;
    logic              rd;
    logic [GPR_AW-1:0] rd_addr;
    logic              div;
    logic              load;
    logic              store;
    logic              legal;
  } idu0_out_t;

  typedef enum logic {
    DIV_IDLE = 1'b0,
    DIV_BUSY = 1'b1
  } div_state_e;

endpackage

// File: rtl/idu_scoreboard.sv
// rtl/idu_scoreboard.sv - 32-entry pending-write scoreboard, one set and two clear ports
module idu_scoreboard
  import idu_hazard_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               set_en,
  input  logic [GPR_AW-1:0]  set_addr,
  input  logic               clr0_en,
  input  logic [GPR_AW-1:0]  clr0_addr,
  input  logic               clr1_en,
  input  logic [GPR_AW-1:0]  clr1_addr,
  input  logic [GPR_AW-1:0]  rd0_addr,
  input  logic [GPR_AW-1:0]  rd1_addr,
  output logic               rd0_data,
  output logic               rd1_data,
  output logic [NUM_GPR-1:0] sb
);

  logic [NUM_GPR-1:0] set_mask;
  logic [NUM_GPR-1:0] clr_mask;
  logic [NUM_GPR-1:0] sb_next;

  // x0 never has a pending write, so bit 0 is masked out of both sides
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en)  set_mask[set_addr]  = 1'b1;
    if (clr0_en) clr_mask[clr0_addr] = 1'b1;
    if (clr1_en) clr_mask[clr1_addr] = 1'b1;
    set_mask[0] = 1'b0;
    clr_mask[0] = 1'b0;
    sb_next = (sb & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sb <= '0;
    else        sb <= sb_next;
  end

  assign rd0_data = sb[rd0_addr];
  assign rd1_data = sb[rd1_addr];

  always @(posedge clk) begin
    if (rst_n) assert ((set_mask & clr_mask) == '0);
  end

endmodule

// File: rtl/idu_hazard_ctrl.sv
// rtl/idu_hazard_ctrl.sv - decode issue control: RAW/WAW scoreboard, divider FSM, mem-op limit
module idu_hazard_ctrl
  import idu_hazard_ctrl_pkg::*;
#(
  parameter int MAX_MEM_OPS = 4,
  parameter int CNT_W       = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  idu0_out_t          idu0_out,
  input  logic               idu0_valid,
  input  logic               flush,
  input  logic               div_wb_valid,
  input  logic [GPR_AW-1:0]  div_wb_rd,
  input  logic               lsu_done,
  input  logic               lsu_wb_valid,
  input  logic [GPR_AW-1:0]  lsu_wb_rd,
  output logic               pipe_stall,
  output logic               issue_valid,
  output logic               div_busy,
  output logic [CNT_W-1:0]   mem_cnt,
  output logic [NUM_GPR-1:0] scoreboard
);

  localparam logic [CNT_W-1:0] MEM_MAX = CNT_W'(MAX_MEM_OPS);

  div_state_e div_state, div_state_next;
  logic [CNT_W-1:0] mem_cnt_next;
  logic rs1_pend, rs2_pend;
  logic raw, waw, struct_haz;
  logic mem_op, mem_inc, sb_set;
  logic legal_unused;

  // Illegal instructions issue normally; traps are raised downstream
  assign legal_unused = idu0_out.legal;

  idu_scoreboard u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_en    (sb_set),
    .set_addr  (idu0_out.rd_addr),
    .clr0_en   (div_wb_valid),
    .clr0_addr (div_wb_rd),
    .clr1_en   (lsu_wb_valid),
    .clr1_addr (lsu_wb_rd),
    .rd0_addr  (idu0_out.rs1_addr),
    .rd1_addr  (idu0_out.rs2_addr),
    .rd0_data  (rs1_pend),
    .rd1_data  (rs2_pend),
    .sb        (scoreboard)
  );

  assign div_busy = (div_state == DIV_BUSY);
  assign mem_op   = idu0_out.load | idu0_out.store;

  // No writeback bypass: a clearing writeback still stalls its own cycle
  assign raw = (idu0_out.rs1 && idu0_out.rs1_addr != '0 && rs1_pend) ||
               (idu0_out.rs2 && idu0_out.rs2_addr != '0 && rs2_pend);
  assign waw = idu0_out.rd && idu0_out.rd_addr != '0 && scoreboard[idu0_out.rd_addr];
  assign struct_haz = (idu0_out.div && div_busy) || (mem_op && mem_cnt == MEM_MAX);

  assign pipe_stall  = idu0_valid && !flush && (raw || waw || struct_haz);
  assign issue_valid = idu0_valid && !flush && !pipe_stall;

  assign sb_set  = issue_valid && idu0_out.rd && idu0_out.rd_addr != '0 &&
                   (idu0_out.div || idu0_out.load);
  assign mem_inc = issue_valid && mem_op;

  always_comb begin
    div_state_next = div_state;
    case (div_state)
      DIV_IDLE: if (issue_valid && idu0_out.div) div_state_next = DIV_BUSY;
      DIV_BUSY: if (div_wb_valid)                div_state_next = DIV_IDLE;
      default:                                   div_state_next = DIV_IDLE;
    endcase
  end

  always_comb begin
    mem_cnt_next = mem_cnt;
    if (mem_inc && !lsu_done) begin
      if (mem_cnt != MEM_MAX) mem_cnt_next = mem_cnt + CNT_W'(1);
    end else if (lsu_done && !mem_inc) begin
      if (mem_cnt != '0) mem_cnt_next = mem_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_state <= DIV_IDLE;
      mem_cnt   <= '0;
    end else begin
      div_state <= div_state_next;
      mem_cnt   <= mem_cnt_next;
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(div_wb_valid && div_state == DIV_IDLE));
      assert (!(lsu_done && !mem_inc && mem_cnt == '0));
    end
  end

endmodule

// File: tb/tb_idu_hazard_ctrl.sv
// tb/tb_idu_hazard_ctrl.sv - directed bench with behavioural issue model for idu_hazard_ctrl
module tb_idu_hazard_ctrl;
  import idu_hazard_ctrl_pkg::*;

  localparam int MAX = 4;
  localparam int CW  = 4;
  localparam int K_ADD = 0, K_DIV = 1, K_LW = 2, K_SW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  idu0_out_t ins;
  logic valid, flush, dwv, ld, lwv;
  logic [4:0] dwr, lwr;
  logic pipe_stall, issue_valid, div_busy;
  logic [CW-1:0] mem_cnt;
  logic [31:0] scoreboard;

  int n_pass = 0;
  int n_total = 0;

  idu_hazard_ctrl #(.MAX_MEM_OPS(MAX), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .idu0_out(ins), .idu0_valid(valid), .flush(flush),
    .div_wb_valid(dwv), .div_wb_rd(dwr), .lsu_done(ld), .lsu_wb_valid(lwv),
    .lsu_wb_rd(lwr), .pipe_stall(pipe_stall), .issue_valid(issue_valid),
    .div_busy(div_busy), .mem_cnt(mem_cnt), .scoreboard(scoreboard)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  function automatic idu0_out_t mk(input int k, input int rd, input int rs1, input int rs2);
    idu0_out_t i;
    i = '0;
    i.legal    = 1'b1;
    i.rs1      = 1'b1;
    i.rs1_addr = 5'(rs1);
    i.rs2      = (k != K_LW);
    i.rs2_addr = (k != K_LW) ? 5'(rs2) : 5'd0;
    i.rd       = (k != K_SW);
    i.rd_addr  = (k != K_SW) ? 5'(rd) : 5'd0;
    i.div      = (k == K_DIV);
    i.load     = (k == K_LW);
    i.store    = (k == K_SW);
    return i;
  endfunction

  // Behavioural model: pending-register set, divider occupancy, count of memory ops in flight
  bit sb_m[32];
  bit busy_m;
  int cnt_m;

  function automatic bit m_stall();
    bit hz;
    hz = 0;
    if (!valid || flush) return 0;
    if (ins.rs1 && ins.rs1_addr != 0 && sb_m[ins.rs1_addr]) hz = 1;
    if (ins.rs2 && ins.rs2_addr != 0 && sb_m[ins.rs2_addr]) hz = 1;
    if (ins.rd && ins.rd_addr != 0 && sb_m[ins.rd_addr]) hz = 1;
    if (ins.div && busy_m) hz = 1;
    if ((ins.load || ins.store) && cnt_m == MAX) hz = 1;
    return hz;
  endfunction

  function automatic bit m_issue();
    return valid && !flush && !m_stall();
  endfunction

  function automatic logic [31:0] m_sbvec();
    logic [31:0] v;
    v = 0;
    for (int r = 0; r < 32; r++) if (sb_m[r]) v = v + (32'd1 << r);
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) sb_m[r] <= 0;
      busy_m <= 0;
      cnt_m  <= 0;
    end else begin
      bit iss, nb;
      int nc;
      bit nsb[32];
      iss = m_issue();
      nsb = sb_m;
      if (dwv && dwr != 0) nsb[dwr] = 0;
      if (lwv && lwr != 0) nsb[lwr] = 0;
      if (iss && ins.rd && ins.rd_addr != 0 && (ins.div || ins.load)) nsb[ins.rd_addr] = 1;
      nb = busy_m ? !dwv : (iss && ins.div);
      nc = cnt_m + ((iss && (ins.load || ins.store)) ? 1 : 0) - (ld ? 1 : 0);
      if (nc < 0) nc = 0;
      if (nc > MAX) nc = MAX;
      sb_m   <= nsb;
      busy_m <= nb;
      cnt_m  <= nc;
    end
  end

  always @(negedge clk) begin
    chk("pipe_stall", 32'(pipe_stall), 32'(m_stall()));
    chk("issue_valid", 32'(issue_valid), 32'(m_issue()));
    chk("div_busy", 32'(div_busy), 32'(busy_m));
    chk("mem_cnt", 32'(mem_cnt), 32'(cnt_m));
    chk("scoreboard", scoreboard, m_sbvec());
  end

  task automatic tick();
    @(posedge clk);
    #1;
    dwv = 0; lwv = 0; ld = 0; flush = 0;
  endtask

  initial begin
    ins = '0; valid = 0; flush = 0; dwv = 0; dwr = 0; ld = 0; lwv = 0; lwr = 0;
    #2;
    chk("rst_sb", scoreboard, 32'h0);
    chk("rst_busy", 32'(div_busy), 32'h0);
    chk("rst_cnt", 32'(mem_cnt), 32'h0);
    chk("rst_stall", 32'(pipe_stall), 32'h0);
    @(posedge clk); #1; rst_n = 1;

    // RAW on a divide result
    ins = mk(K_DIV, 5, 1, 2); valid = 1; #1 chk("s1_div_issue", 32'(issue_valid), 32'h1);
    tick(); ins = mk(K_ADD, 6, 5, 1);
    #1 chk("s1_sb_set", scoreboard, 32'h20); chk("s1_add_stall", 32'(pipe_stall), 32'h1);
    tick(); tick();
    tick(); dwv = 1; dwr = 5; #1 chk("s1_stall_on_wb", 32'(pipe_stall), 32'h1);
    tick(); #1 chk("s1_add_issue", 32'(issue_valid), 32'h1); chk("s1_sb_clear", scoreboard, 32'h0);
    tick(); valid = 0;

    // Back-to-back divides
    tick(); ins = mk(K_DIV, 5, 1, 2); valid = 1;
    tick(); ins = mk(K_DIV, 7, 1, 2);
    #1 chk("s2_busy", 32'(div_busy), 32'h1); chk("s2_div2_stall", 32'(pipe_stall), 32'h1);
    tick(); dwv = 1; dwr = 5; #1 chk("s2_stall_on_wb", 32'(pipe_stall), 32'h1);
    tick(); #1 chk("s2_div2_issue", 32'(issue_valid), 32'h1);
    tick(); valid = 0; #1 chk("s2_busy_again", 32'(div_busy), 32'h1); chk("s2_sb7", scoreboard, 32'h80);
    tick(); dwv = 1; dwr = 7;
    tick();

    // Memory-op limit
    for (int i = 0; i < 4; i++) begin
      ins = mk(K_LW, 10 + i, 1, 0); valid = 1;
      tick();
    end
    ins = mk(K_LW, 14, 1, 0);
    #1 chk("s3_cnt_full", 32'(mem_cnt), 32'h4); chk("s3_5th_stall", 32'(pipe_stall), 32'h1);
    chk("s3_sb", scoreboard, 32'h3C00);
    tick(); #1 chk("s3_still_stall", 32'(pipe_stall), 32'h1);
    ld = 1; lwv = 1; lwr = 10;
    tick(); #1 chk("s3_cnt_dec", 32'(mem_cnt), 32'h3); chk("s3_5th_issue", 32'(issue_valid), 32'h1);
    ld = 1; lwv = 1; lwr = 11;
    tick(); valid = 0; #1 chk("s3_cnt_inc_dec", 32'(mem_cnt), 32'h3); chk("s3_sb2", scoreboard, 32'h7000);
    for (int r = 12; r < 15; r++) begin
      ld = 1; lwv = 1; lwr = 5'(r);
      tick();
    end
    #1 chk("s3_drained_cnt", 32'(mem_cnt), 32'h0); chk("s3_drained_sb", scoreboard, 32'h0);

    // x0 destinations/sources, then WAW
    ins = mk(K_LW, 0, 0, 0); valid = 1; #1 chk("s4_lw_x0_issue", 32'(issue_valid), 32'h1);
    tick(); ins = mk(K_ADD, 1, 0, 0);
    #1 chk("s4_add_x0_nostall", 32'(pipe_stall), 32'h0); chk("s4_sb_x0", scoreboard, 32'h0);
    chk("s4_cnt", 32'(mem_cnt), 32'h1);
    tick(); valid = 0; ld = 1;
    tick();
    ins = mk(K_DIV, 3, 1, 2); valid = 1;
    tick(); ins = mk(K_ADD, 3, 1, 2); #1 chk("s4_waw_stall", 32'(pipe_stall), 32'h1);
    tick(); dwv = 1; dwr = 3;
    tick(); #1 chk("s4_waw_issue", 32'(issue_valid), 32'h1);
    tick(); valid = 0;

    // Flush kills only the decode slot
    ins = mk(K_DIV, 8, 1, 2); valid = 1;
    tick(); ins = mk(K_ADD, 9, 8, 0); flush = 1;
    #1 chk("s5_flush_stall", 32'(pipe_stall), 32'h0); chk("s5_flush_issue", 32'(issue_valid), 32'h0);
    tick(); flush = 1; dwv = 1; dwr = 8;
    tick(); valid = 0; #1 chk("s5_sb_clear", scoreboard, 32'h0); chk("s5_idle", 32'(div_busy), 32'h0);

    // Asynchronous reset mid-operation
    ins = mk(K_DIV, 5, 1, 2); valid = 1;
    tick(); ins = mk(K_LW, 3, 1, 0);
    tick(); ins = mk(K_SW, 0, 1, 2);
    tick();
    tick(); valid = 0;
    #1 chk("s6_pre_sb", scoreboard, 32'h28); chk("s6_pre_cnt", 32'(mem_cnt), 32'h3);
    chk("s6_pre_busy", 32'(div_busy), 32'h1);
    #1 rst_n = 0;
    #1 chk("s6_rst_sb", scoreboard, 32'h0); chk("s6_rst_cnt", 32'(mem_cnt), 32'h0);
    chk("s6_rst_busy", 32'(div_busy), 32'h0);
    tick(); tick();
    rst_n = 1; lwv = 1; lwr = 3;
    tick(); #1 chk("s6_late_wb_sb", scoreboard, 32'h0); chk("s6_late_cnt", 32'(mem_cnt), 32'h0);
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
